// File: rtl/team_06_button_conditioner_pkg.sv
// Shared definitions for the team_06 button conditioner: button bit
// positions and the per-channel debounce state encoding.
package team_06_pkg;

  localparam int unsigned BTN_PTT    = 0;
  localparam int unsigned BTN_NG     = 1;
  localparam int unsigned BTN_EFFECT = 2;
  localparam int unsigned BTN_MUTE   = 3;

  typedef enum logic [1:0] {
    IDLE_LO,
    PEND_HI,
    IDLE_HI,
    PEND_LO
  } db_state_t;

endpackage

// File: rtl/team_06_button_conditioner_debounce.sv
// Single-channel button debouncer: two-flop synchronizer, stability counter
// and four-state channel FSM. The level changes only after DEBOUNCE_CYCLES
// consecutive equal synchronized samples; press pulses once per accepted rise.
module team_06_debounce
  import team_06_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned CNT_W           = 17
) (
  input  logic clk,
  input  logic nrst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  // Two-flop synchronizer for the asynchronous pad input.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Channel FSM next state; the counter never wraps since PEND exits at CntLast.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    unique case (state_q)
      IDLE_LO: begin
        if (sync2_q) begin
          state_d = PEND_HI;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end
      PEND_HI: begin
        if (!sync2_q) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      IDLE_HI: begin
        if (!sync2_q) begin
          state_d = PEND_LO;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end
      PEND_LO: begin
        if (sync2_q) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Channel state, counter and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/team_06_button_conditioner.sv
// Button conditioner for the team_06 control FSM: four independent debounced
// channels mapped onto the FSM level inputs plus per-button press pulses.
// Optional macro TEAM06_PTT_LATCH_EN turns ptt_en into a press-toggled latch.
module team_06_button_conditioner
  import team_06_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned CNT_W           = 17
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] btn_raw,
  output logic       ptt_en,
  output logic       ng_en,
  output logic       effect,
  output logic       mute,
  output logic [3:0] btn_press
);

  logic [3:0] level_w;
  logic [3:0] press_w;

  for (genvar i = 0; i < 4; i++) begin : g_chan
    team_06_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk  (clk),
      .nrst (nrst),
      .raw  (btn_raw[i]),
      .level(level_w[i]),
      .press(press_w[i])
    );
  end

`ifdef TEAM06_PTT_LATCH_EN
  logic ptt_latch_q;

  // Each accepted ptt press flips the latch; releases are ignored.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ptt_latch_q <= 1'b0;
    end else if (press_w[BTN_PTT]) begin
      ptt_latch_q <= ~ptt_latch_q;
    end
  end

  assign ptt_en = ptt_latch_q;
`else
  assign ptt_en = level_w[BTN_PTT];
`endif

  assign ng_en     = level_w[BTN_NG];
  assign effect    = level_w[BTN_EFFECT];
  assign mute      = level_w[BTN_MUTE];
  assign btn_press = press_w;

endmodule

// File: tb/tb_team_06_button_conditioner.sv
// Directed bench for team_06_button_conditioner with an event scoreboard:
// each clean input change pushes the expected output event, and every cycle
// the bench pops due events and compares levels and press pulses.
module tb_team_06_button_conditioner;

  localparam int unsigned D   = 8;
  localparam int          LAT = D + 2;

  logic       clk = 1'b0;
  logic       nrst;
  logic [3:0] btn_raw;
  logic       ptt_en, ng_en, effect, mute;
  logic [3:0] btn_press;

  team_06_button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (4)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .btn_raw  (btn_raw),
    .ptt_en   (ptt_en),
    .ng_en    (ng_en),
    .effect   (effect),
    .mute     (mute),
    .btn_press(btn_press)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
    logic [3:0] val;
    logic [3:0] press;
  } ev_t;

  ev_t        sb[$];
  int         cyc;
  logic [3:0] exp_lvl;
  logic       ptt_model;
  int         tests;
  int         fails;

`ifdef TEAM06_PTT_LATCH_EN
  localparam bit Latch = 1'b1;
`else
  localparam bit Latch = 1'b0;
`endif

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input int lat, input logic [3:0] mask, input logic [3:0] val,
                      input logic [3:0] press);
    ev_t e;
    e.cyc   = cyc + lat;
    e.mask  = mask;
    e.val   = val;
    e.press = press;
    sb.push_back(e);
  endtask

  // Clean change of the raw buttons; queues what the outputs must do LAT edges later.
  task automatic drive(input logic [3:0] new_raw);
    logic [3:0] rise, fall, mask, val;
    rise = new_raw & ~btn_raw;
    fall = btn_raw & ~new_raw;
    mask = (rise | fall) & 4'b1110;
    val  = new_raw;
    if (Latch) begin
      if (rise[0]) begin
        ptt_model = ~ptt_model;
        mask[0]   = 1'b1;
        val[0]    = ptt_model;
      end
    end else begin
      mask[0] = rise[0] | fall[0];
    end
    btn_raw = new_raw;
    if ((mask | rise) != 4'b0000) push(LAT, mask, val, rise);
  endtask

  task automatic step();
    logic [3:0] exp_press;
    @(posedge clk);
    cyc++;
    #1;
    exp_press = 4'b0000;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_lvl   = (exp_lvl & ~sb[0].mask) | (sb[0].val & sb[0].mask);
      exp_press = exp_press | sb[0].press;
      sb.delete(0);
    end
    check("level", {mute, effect, ng_en, ptt_en}, exp_lvl);
    check("press", btn_press, exp_press);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    cyc       = 0;
    exp_lvl   = 4'b0000;
    ptt_model = 1'b0;
    nrst      = 1'b0;
    btn_raw   = 4'b0000;
    #12;
    check("rst_level", {mute, effect, ng_en, ptt_en}, 4'b0000);
    check("rst_press", btn_press, 4'b0000);
    @(posedge clk);
    #1;
    nrst = 1'b1;

    // Idle: nothing may move.
    steps(50);

    // Mute press and release.
    drive(4'b1000);
    steps(20);
    drive(4'b0000);
    steps(15);

    // Bouncy effect press: 5 high, 2 low, then stable high.
    btn_raw = 4'b0100;
    steps(5);
    btn_raw = 4'b0000;
    steps(2);
    drive(4'b0100);
    steps(15);
    drive(4'b0000);
    steps(15);

    // Simultaneous ptt and noise-gate presses.
    drive(4'b0011);
    steps(15);
    drive(4'b0000);
    steps(15);

    // Reset mid-count discards the pending ng press.
    drive(4'b0010);
    steps(6);
    nrst = 1'b0;
    sb.delete();
    exp_lvl   = 4'b0000;
    ptt_model = 1'b0;
    #1;
    check("rst_mid_level", {mute, effect, ng_en, ptt_en}, 4'b0000);
    check("rst_mid_press", btn_press, 4'b0000);
    step();
    nrst = 1'b1;
    push(LAT, 4'b0010, 4'b0010, 4'b0010);
    steps(15);
    drive(4'b0000);
    steps(15);

    // Two separated 20-cycle ptt presses.
    drive(4'b0001);
    steps(20);
    drive(4'b0000);
    steps(20);
    drive(4'b0001);
    steps(20);
    drive(4'b0000);
    steps(20);

    tests++;
    assert (sb.size() == 0)
    else begin
      fails++;
      $error("FAIL sb_empty observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/team_06_button_conditioner.md
Name: team_06_button_conditioner

Overview:
- Front end for the team_06 control FSM: takes the four raw, asynchronous user buttons (push-to-talk, noise gate, effect, mute) from the pads.
- Synchronizes and debounces each button, then drives the clean level inputs `ptt_en`, `ng_en`, `effect` and `mute` that the FSM consumes.
- The FSM does its own rising-edge detection, so this block delivers glitch-free levels plus one-cycle press pulses for any other consumer.

Parameters:
- DEBOUNCE_CYCLES, 100000, consecutive stable synchronized samples required before a clean level changes (10 ms at 10 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 17, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock
- nrst  input  1  asynchronous, active-low reset
- btn_raw  input  4  raw pad levels, active-high; [0]=ptt, [1]=noise gate, [2]=effect, [3]=mute
- ptt_en  output  1  debounced ptt level (FSM ptt_en)
- ng_en  output  1  debounced noise-gate button level (FSM ng_en)
- effect  output  1  debounced effect button level (FSM effect)
- mute  output  1  debounced mute button level (FSM mute)
- btn_press  output  4  one-cycle pulse on each clean 0->1 transition, same bit order as btn_raw

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, nrst).
- Reset: all synchronizer flops, counters and clean levels are 0, channel states are IDLE_LO, and btn_press is 0. Reset may assert mid-count; the count is discarded.
- Synchronizer: two-flop chain per bit. sync[i] lags btn_raw[i] by 2 edges.
- Channel FSM, one per bit, with four states:
  - IDLE_LO: sync=1 -> PEND_HI with cnt=1; otherwise hold with cnt=0.
  - PEND_HI:
    - sync=0 -> IDLE_LO with cnt=0 (bounce rejected).
    - sync=1 and cnt==DEBOUNCE_CYCLES-1 -> IDLE_HI; clean level set to 1; btn_press[i] pulses this edge.
    - otherwise cnt+1.
  - IDLE_HI: sync=0 -> PEND_LO with cnt=1; otherwise hold.
  - PEND_LO: mirror of PEND_HI. Clean level goes to 0 on completion; no pulse on release.
- Latency: a clean raw step at edge 0 changes the clean level on edge 2+DEBOUNCE_CYCLES. btn_press is registered and coincides with the level's first high cycle.
- Pulse width: btn_press is high exactly one cycle per accepted press, however long the button is held.
- Glitch rejection: any pulse or gap shorter than DEBOUNCE_CYCLES synchronized samples produces no output change.
- Independence: channels never interact. Simultaneous presses on several bits yield simultaneous, independent pulses.
- Counter: saturates by construction and never wraps, because the state leaves PEND at DEBOUNCE_CYCLES-1.
- Timing: outputs are registered only; there is no combinational path from btn_raw to any output.

Optional Feature:
- Macro: TEAM06_PTT_LATCH_EN.
- Defined: ptt_en becomes a toggle. Each accepted ptt press (btn_press[0]) inverts a latch flop, which resets to 0, and ptt_en drives that latch. Releasing the button has no effect.
- Undefined: ptt_en is the momentary debounced level, high only while the button is held.
- btn_press[0] behaves identically in both builds.

Decomposition:
- Package team_06_pkg holds:
  - localparam button indices: BTN_PTT=0, BTN_NG=1, BTN_EFFECT=2, BTN_MUTE=3.
  - typedef enum logic [1:0] db_state_t {IDLE_LO, PEND_HI, IDLE_HI, PEND_LO}.
- Sub-module team_06_debounce holds one synchronizer, counter and channel FSM. It is parameterized by DEBOUNCE_CYCLES/CNT_W, has ports clk, nrst, raw, level, press, and is instantiated four times via generate.
- The top level only adds bit mapping and the optional ptt latch.

Test Plan (DEBOUNCE_CYCLES=8, CNT_W=4 for simulation):
- Reset, then hold btn_raw=4'b0000 for 50 cycles -> all outputs 0; btn_press never asserts.
- Raise btn_raw[3] at edge 0 and hold -> mute=1 first at edge 10; btn_press[3] high only at edge 10; release -> mute=0 10 edges after the release, no pulse.
- On btn_raw[2], apply high for 5 cycles, low for 2, then high and hold -> no change during the bounce; effect=1 exactly 10 edges after the final rise.
- Raise btn_raw[0] and btn_raw[1] on the same edge -> ptt_en and ng_en both rise on edge 10; btn_press=4'b0011 for one cycle.
- Raise btn_raw[1] and pull nrst low at edge 6 for 1 cycle -> ng_en stays 0; after release ng_en=1 only 10 edges after nrst deasserts.
- Build with TEAM06_PTT_LATCH_EN, apply two separated 20-cycle ptt presses -> ptt_en=1 after the first press and 0 after the second; without the macro, ptt_en follows each press (high 20 cycles, delayed 10).
